// File: rtl/dma_periph_requester.sv
// Peripheral side of an 8237A-style DREQ/DACK handshake: FIFO-buffered source
// words are offered to the DMA channel one acknowledged read strobe at a time.
module dma_periph_requester #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int AW     = 3
) (
    input  logic              clk,
    input  logic              Reset_n,
    input  logic              start,
    input  logic              demand,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              DACK,
    input  logic              dma_rd,
    input  logic              TC,
    output logic              DREQ,
    output logic [DATA_W-1:0] data_out,
    output logic [AW:0]       count,
    output logic              full,
    output logic              empty,
    output logic              done,
    output logic              overflow,
    output logic              underflow
);

    typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

    state_t            state;
    state_t            state_nxt;
    logic              dreq_nxt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wptr;
    logic [AW-1:0]     rptr;
    logic              enabled;
    logic              xfer;
    logic              push;
    logic              pop;
    logic              tc_accept;

    assign xfer      = DACK & dma_rd;
    assign full      = (count == (AW+1)'(DEPTH));
    assign empty     = (count == '0);
    // A write into a full FIFO is still accepted when the head leaves in the same cycle.
    assign push      = wr_en & (~full | xfer);
    assign pop       = xfer & ~empty;
    assign tc_accept = (state == REQ) & pop & TC;
    assign data_out  = empty ? '0 : mem[rptr];

    always_ff @(posedge clk) begin
        if (push)
            mem[wptr] <= wr_data;
    end

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push)
                wptr <= wptr + 1'b1;
            if (pop)
                rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            enabled   <= 1'b0;
            done      <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (start) begin
                enabled <= 1'b1;
                done    <= 1'b0;
            end else if (tc_accept) begin
                enabled <= 1'b0;
                done    <= 1'b1;
            end
            if (wr_en && full && !xfer)
                overflow <= 1'b1;
            if (xfer && empty)
                underflow <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
            DREQ  <= 1'b0;
        end else begin
            state <= state_nxt;
            DREQ  <= dreq_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (enabled && !empty)
                    state_nxt = REQ;
            end
            REQ: begin
                if (pop) begin
                    if (TC)
                        state_nxt = IDLE;
                    else if (!demand)
                        state_nxt = HOLD;
                    else if (count == (AW+1)'(1) && !push)
                        state_nxt = IDLE;
                end else if (empty && !xfer) begin
                    state_nxt = IDLE;
                end
            end
            HOLD:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        // A start pulse aborts any outstanding request.
        if (start)
            state_nxt = IDLE;
    end

    always_comb begin
        dreq_nxt = (state_nxt == REQ);
    end

endmodule

// File: tb/tb_dma_periph_requester.sv
// Directed bench for dma_periph_requester: a vector table for single and demand
// mode, plus hand-written sequences for TC, full/overflow, underflow and reset.
module tb_dma_periph_requester;

    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int AW    = 3;
    localparam int NVEC  = 21;

    logic          clk = 1'b0;
    logic          Reset_n;
    logic          start;
    logic          demand;
    logic          wr_en;
    logic [DW-1:0] wr_data;
    logic          DACK;
    logic          dma_rd;
    logic          TC;
    logic          DREQ;
    logic [DW-1:0] data_out;
    logic [AW:0]   count;
    logic          full;
    logic          empty;
    logic          done;
    logic          overflow;
    logic          underflow;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dma_periph_requester #(.DATA_W(DW), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk(clk), .Reset_n(Reset_n), .start(start), .demand(demand),
        .wr_en(wr_en), .wr_data(wr_data), .DACK(DACK), .dma_rd(dma_rd), .TC(TC),
        .DREQ(DREQ), .data_out(data_out), .count(count), .full(full), .empty(empty),
        .done(done), .overflow(overflow), .underflow(underflow)
    );

    // Inputs for one cycle; head is data_out before the edge, the rest after it.
    typedef struct packed {
        logic          st;
        logic          dm;
        logic          we;
        logic [DW-1:0] wd;
        logic          dk;
        logic          rd;
        logic          tc;
        logic [DW-1:0] head;
        logic          dreq;
        logic [AW:0]   cnt;
        logic          dn;
    } vec_t;

    vec_t tbl [NVEC];

    function automatic vec_t mk(int st, int dm, int we, int wd, int dk, int rd, int tc,
                                int head, int dreq, int cnt, int dn);
        vec_t v;
        v.st   = 1'(st);
        v.dm   = 1'(dm);
        v.we   = 1'(we);
        v.wd   = 8'(wd);
        v.dk   = 1'(dk);
        v.rd   = 1'(rd);
        v.tc   = 1'(tc);
        v.head = 8'(head);
        v.dreq = 1'(dreq);
        v.cnt  = 4'(cnt);
        v.dn   = 1'(dn);
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input int st, input int we, input int wd, input int dk,
                         input int rd, input int tc);
        start   = 1'(st);
        wr_en   = 1'(we);
        wr_data = 8'(wd);
        DACK    = 1'(dk);
        dma_rd  = 1'(rd);
        TC      = 1'(tc);
        @(posedge clk);
        #1;
    endtask

    initial begin
        Reset_n = 1'b0;
        start = 0; demand = 0; wr_en = 0; wr_data = '0; DACK = 0; dma_rd = 0; TC = 0;

        // Single mode: A5 then 3C, one xfer per DREQ assertion.
        tbl[0]  = mk(1,0,0,'h00,0,0,0, 'h00,0,0,0);
        tbl[1]  = mk(0,0,1,'hA5,0,0,0, 'h00,0,1,0);
        tbl[2]  = mk(0,0,1,'h3C,0,0,0, 'hA5,1,2,0);
        tbl[3]  = mk(0,0,0,'h00,1,0,0, 'hA5,1,2,0);
        tbl[4]  = mk(0,0,0,'h00,1,1,0, 'hA5,0,1,0);
        tbl[5]  = mk(0,0,0,'h00,1,0,0, 'h3C,0,1,0);
        tbl[6]  = mk(0,0,0,'h00,1,0,0, 'h3C,1,1,0);
        tbl[7]  = mk(0,0,0,'h00,1,1,0, 'h3C,0,0,0);
        tbl[8]  = mk(0,0,0,'h00,0,0,0, 'h00,0,0,0);
        tbl[9]  = mk(0,0,0,'h00,0,0,0, 'h00,0,0,0);
        // Demand mode: four words, DREQ held until the last one leaves.
        tbl[10] = mk(1,1,0,'h00,0,0,0, 'h00,0,0,0);
        tbl[11] = mk(0,1,1,'h11,0,0,0, 'h00,0,1,0);
        tbl[12] = mk(0,1,1,'h22,0,0,0, 'h11,1,2,0);
        tbl[13] = mk(0,1,1,'h33,0,0,0, 'h11,1,3,0);
        tbl[14] = mk(0,1,1,'h44,0,0,0, 'h11,1,4,0);
        tbl[15] = mk(0,1,0,'h00,1,1,0, 'h11,1,3,0);
        tbl[16] = mk(0,1,0,'h00,1,0,1, 'h22,1,3,0);
        tbl[17] = mk(0,1,0,'h00,1,1,0, 'h22,1,2,0);
        tbl[18] = mk(0,1,0,'h00,1,1,0, 'h33,1,1,0);
        tbl[19] = mk(0,1,0,'h00,1,1,0, 'h44,0,0,0);
        tbl[20] = mk(0,1,0,'h00,1,0,0, 'h00,0,0,0);

        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst DREQ", DREQ, 0);
        chk("rst count", count, 0);
        chk("rst empty", empty, 1);
        chk("rst full", full, 0);
        chk("rst done", done, 0);
        chk("rst overflow", overflow, 0);
        chk("rst underflow", underflow, 0);
        chk("rst data_out", data_out, 0);
        Reset_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < NVEC; i++) begin
            demand = tbl[i].dm;
            chk($sformatf("v%0d head", i), data_out, tbl[i].head);
            drive(tbl[i].st, tbl[i].we, tbl[i].wd, tbl[i].dk, tbl[i].rd, tbl[i].tc);
            chk($sformatf("v%0d DREQ", i), DREQ, tbl[i].dreq);
            chk($sformatf("v%0d count", i), count, tbl[i].cnt);
            chk($sformatf("v%0d done", i), done, tbl[i].dn);
        end

        // Terminal count on the second of five words.
        demand = 1'b1;
        for (int k = 0; k < 5; k++)
            drive(0, 1, 'h50 + k, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        chk("tc DREQ queued", DREQ, 1);
        chk("tc count queued", count, 5);
        chk("tc head1", data_out, 'h50);
        drive(0, 0, 0, 1, 1, 0);
        chk("tc count1", count, 4);
        chk("tc head2", data_out, 'h51);
        drive(0, 0, 0, 1, 1, 1);
        chk("tc DREQ", DREQ, 0);
        chk("tc done", done, 1);
        chk("tc count", count, 3);
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 0, 0, 0, 0);
            chk($sformatf("tc hold DREQ%0d", k), DREQ, 0);
        end
        drive(1, 0, 0, 0, 0, 0);
        chk("restart DREQ", DREQ, 0);
        chk("restart done", done, 0);
        drive(0, 0, 0, 0, 0, 0);
        chk("restart DREQ+2", DREQ, 1);
        for (int k = 0; k < 3; k++)
            drive(0, 0, 0, 1, 1, 0);
        chk("drain DREQ", DREQ, 0);
        chk("drain count", count, 0);

        // Full FIFO: write with concurrent pop is kept, write alone is dropped.
        for (int k = 0; k < 8; k++)
            drive(0, 1, 'h60 + k, 0, 0, 0);
        chk("full flag", full, 1);
        chk("full count", count, 8);
        chk("full overflow0", overflow, 0);
        chk("full head", data_out, 'h60);
        drive(0, 1, 'hAA, 1, 1, 0);
        chk("wr+xfer count", count, 8);
        chk("wr+xfer overflow", overflow, 0);
        chk("wr+xfer full", full, 1);
        drive(0, 1, 'h99, 0, 0, 0);
        chk("ovf flag", overflow, 1);
        chk("ovf count", count, 8);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("full drain head%0d", k), data_out, (k < 7) ? ('h61 + k) : 'hAA);
            drive(0, 0, 0, 1, 1, 0);
        end
        chk("full drain empty", empty, 1);
        chk("full drain underflow", underflow, 0);

        // Transfer strobe with nothing queued.
        drive(0, 0, 0, 1, 1, 0);
        chk("unf flag", underflow, 1);
        chk("unf count", count, 0);
        chk("unf DREQ", DREQ, 0);
        chk("unf empty", empty, 1);
        drive(0, 1, 'h77, 0, 0, 0);
        chk("unf next head", data_out, 'h77);
        chk("unf next count", count, 1);

        // Reset while requesting with three words queued.
        drive(0, 1, 'h88, 0, 0, 0);
        drive(0, 1, 'h99, 0, 0, 0);
        chk("pre-rst DREQ", DREQ, 1);
        chk("pre-rst count", count, 3);
        #2;
        Reset_n = 1'b0;
        #1;
        chk("mid-rst DREQ", DREQ, 0);
        chk("mid-rst count", count, 0);
        chk("mid-rst empty", empty, 1);
        chk("mid-rst done", done, 0);
        chk("mid-rst overflow", overflow, 0);
        chk("mid-rst underflow", underflow, 0);
        chk("mid-rst data_out", data_out, 0);
        @(negedge clk);
        Reset_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        chk("post-rst DREQ", DREQ, 0);
        chk("post-rst count", count, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
